// File: rtl/div_iter_unit_pkg.sv
//==============================================================================
// Module      : div_iter_unit_pkg
// Description : Shared encodings and constants for the iterative divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_iter_unit_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CALC  = 2'd2,
        ST_FIX   = 2'd3
    } state_t;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/div_iter_unit_negate.sv
//==============================================================================
// Module      : div_negate
// Description : Conditional two's-complement negation (out = neg ? -in : in).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

`default_nettype wire

// File: rtl/div_iter_unit.sv
//==============================================================================
// Module      : div_iter_unit
// Description : Iterative restoring divider (DIV/DIVU/REM/REMU) that borrows
//               the ALU's DSP subtractor. Optional macro DIV_ITER_EARLY_OUT_EN
//               finishes in CHECK when |dividend| < |divisor|.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] sub_a,
    output logic [XLEN-1:0] sub_b,
    input  logic [XLEN-1:0] sub_diff,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    q_q, q_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_signed_q, is_signed_d;
    logic               is_rem_q, is_rem_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               in_signed;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic [XLEN-1:0]    rem_sh;
    logic               borrow;
    logic               div0_w, ovf_w;
    logic [XLEN-1:0]    fix_in, fix_out;
    logic               fix_neg;

    assign in_signed = (op == OP_DIV) || (op == OP_REM);

    div_negate #(.WIDTH(XLEN)) u_neg_a (
        .i_val (dividend),
        .i_neg (in_signed & dividend[XLEN-1]),
        .o_val (mag_a)
    );

    div_negate #(.WIDTH(XLEN)) u_neg_b (
        .i_val (divisor),
        .i_neg (in_signed & divisor[XLEN-1]),
        .o_val (mag_b)
    );

    // DIV negates by the sign mismatch, REM follows the dividend's sign.
    assign fix_in  = is_rem_q ? rem_q : q_q;
    assign fix_neg = is_rem_q ? sign_a_q : (sign_a_q ^ sign_b_q);

    div_negate #(.WIDTH(XLEN)) u_neg_res (
        .i_val (fix_in),
        .i_neg (fix_neg),
        .o_val (fix_out)
    );

    assign rem_sh = {rem_q[XLEN-2:0], q_q[XLEN-1]};

    always_comb begin
        sub_a = '0;
        sub_b = '0;
        case (state_q)
            ST_CHECK: begin
                sub_a = q_q;
                sub_b = dvsr_q;
            end
            ST_CALC: begin
                sub_a = rem_sh;
                sub_b = dvsr_q;
            end
            default: ;
        endcase
    end

    // Unsigned sub_a < sub_b derived from the external difference.
    assign borrow = (sub_a[XLEN-1] ^ sub_b[XLEN-1]) ? sub_b[XLEN-1] : sub_diff[XLEN-1];

    assign div0_w = (dvsr_q == '0);
    assign ovf_w  = is_signed_q & sign_a_q & sign_b_q & (q_q == OVF_QUOT) & (dvsr_q == XLEN'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_signed_d = in_signed;
                    is_rem_d    = (op == OP_REM) || (op == OP_REMU);
                    sign_a_d    = in_signed & dividend[XLEN-1];
                    sign_b_d    = in_signed & divisor[XLEN-1];
                    q_d         = mag_a;
                    rem_d       = '0;
                    dvsr_d      = mag_b;
                    div0_d      = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cnt_d  = '1;
                div0_d = div0_w;
                ovf_d  = ovf_w;
`ifdef DIV_ITER_EARLY_OUT_EN
                if (div0_w || ovf_w || borrow) begin
`else
                if (div0_w || ovf_w) begin
`endif
                    // Fast path: remainder is the dividend magnitude, quotient 0.
                    rem_d   = q_q;
                    q_d     = '0;
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (borrow && !rem_q[XLEN-1]) begin
                    rem_d = rem_sh;
                    q_d   = {q_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d = sub_diff;
                    q_d   = {q_q[XLEN-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (ovf_q) begin
                    result_d = is_rem_q ? '0 : OVF_QUOT;
                end else if (div0_q && !is_rem_q) begin
                    result_d = DIV0_QUOT;
                end else begin
                    result_d = fix_out;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
//==============================================================================
// Module      : tb_div_iter_unit
// Description : Directed self-checking bench for div_iter_unit with a
//               behavioural DSP subtractor (sub_diff = sub_a - sub_b).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic [31:0] sub_diff;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_ITER_EARLY_OUT_EN
    localparam int EO_CYC = 3;
`else
    localparam int EO_CYC = 35;
`endif

    div_iter_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .sub_a    (sub_a),
        .sub_b    (sub_b),
        .sub_diff (sub_diff),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    assign sub_diff = sub_a - sub_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [1:0] o, input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (!o[0] && v[31]) r = (~v) + 32'd1;
        return r;
    endfunction

    // Start in cycle 0, then watch up to 60 cycles for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int          done_cyc;
        logic        busy_ok;
        logic [31:0] sa, sb;
        @(posedge clk); #1;
        start = 1'b1; op = o; dividend = a; divisor = b;
        done_cyc = -1;
        busy_ok  = 1'b1;
        sa = '0;
        sb = '0;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 1) begin
                sa = sub_a;
                sb = sub_b;
            end
            if (busy !== (cyc < exp_cyc)) busy_ok = 1'b0;
            if (done === 1'b1) done_cyc = cyc;
        end
        check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({tag, ".result"}, result, exp_res);
        check({tag, ".busy_profile"}, {31'd0, busy_ok}, 32'd1);
        check({tag, ".check_sub_a"}, sa, mag(o, a));
        check({tag, ".check_sub_b"}, sb, mag(o, b));
        @(posedge clk); #1;
        check({tag, ".done_pulse_low"}, {31'd0, done}, 32'd0);
        check({tag, ".result_held"}, result, exp_res);
    endtask

    initial begin
        int   seen_done;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",   {31'd0, busy}, 32'd0);
        check("reset.done",   {31'd0, done}, 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.sub_a",  sub_a, 32'd0);
        check("reset.sub_b",  sub_b, 32'd0);
        rst = 1'b0;

        run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         35);
        run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          35);
        run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35);
        run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35);
        run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35);
        run_op("rem_min_3",    2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  35);
        run_op("div_min_3",    2'b00, 32'h8000_0000,  32'd3,          32'hD555_5556,  35);
        run_op("remu_big",     2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  35);
        run_op("divu_big",     2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          35);
        run_op("divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  3);
        run_op("rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  3);
        run_op("div_m5_0",     2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  3);
        run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3);
        run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          3);
        run_op("remu_3_10",    2'b11, 32'd3,          32'd10,         32'd3,          EO_CYC);
        run_op("div_m3_10",    2'b00, 32'hFFFF_FFFD,  32'd10,         32'd0,          EO_CYC);
        run_op("rem_m3_10",    2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EO_CYC);

        // Abort: reset pulse in cycle 10 of a long division.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3;
        seen_done = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) seen_done++;
        end
        rst = 1'b1;
        #1;
        check("abort.busy_async", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
        check("abort.result",  result, 32'd0);
        check("abort.busy",    {31'd0, busy}, 32'd0);

        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
